// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencing controller (PC freeze/redirect, IF/ID write/flush).
// Latency: control outputs are combinational from state and inputs; halted/imem_err are registered.
// Backpressure: a low imem_ready or a hazard_stall freezes the PC in the same cycle it is seen.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   imem_ready          instruction memory returned valid data this cycle
//   hazard_stall        decode hazard, hold PC and IF/ID
//   branch,             redirect taken when branch != 0; branch_target is the new PC
//   branch_target
//   halt_dec            HLT decoded in IF this cycle
//   imem_req            fetch request to instruction memory
//   pc_freeze, pc_sel,  PC register hold, redirect mux select and redirect address
//   pc_target
//   ifid_write,         IF/ID load enable and NOP-bubble insert
//   ifid_flush
//   halted, imem_err    sticky status flops, cleared only by reset
//
// Optional build macro FETCH_PERF_CNT_EN adds stall_cnt/flush_cnt, 16-bit saturating
// counters of frozen / flushed cycles outside BOOT and HALTED.

module fetch_ctrl #(
  parameter int ADDR_W      = 16,
  // Maximum number of WAIT_MEM cycles before the fetch is declared dead (1..255).
  parameter int MEM_TIMEOUT = 64,
  // Watchdog counter width; must be able to hold MEM_TIMEOUT.
  parameter int TMO_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              hazard_stall,
  input  logic [1:0]        branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_dec,
  output logic              imem_req,
  output logic              pc_freeze,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              halted,
  output logic              imem_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_REDIRECT = 3'd3,
    S_HALTED   = 3'd4
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic              redir_q, redir_d;     // a redirect arrived during an outstanding fetch
  logic [ADDR_W-1:0] tgt_q,   tgt_d;       // youngest redirect target seen in WAIT_MEM
  logic [TMO_W-1:0]  tmo_q,   tmo_d;       // WAIT_MEM cycle count, 1 in the first wait cycle
  logic              halted_q, halted_d;
  logic              imem_err_q, imem_err_d;

  logic branch_vld;
  assign branch_vld = (branch != 2'b00);

  // ------------------------------------------------------------------
  // State and status registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      redir_q    <= 1'b0;
      tgt_q      <= '0;
      tmo_q      <= '0;
      halted_q   <= 1'b0;
      imem_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      redir_q    <= redir_d;
      tgt_q      <= tgt_d;
      tmo_q      <= tmo_d;
      halted_q   <= halted_d;
      imem_err_q <= imem_err_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and control outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    redir_d    = redir_q;
    tgt_d      = tgt_q;
    tmo_d      = tmo_q;
    halted_d   = halted_q;
    imem_err_d = imem_err_q;

    imem_req   = 1'b0;
    pc_freeze  = 1'b0;
    pc_sel     = 1'b0;
    pc_target  = '0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;

    case (state_q)
      S_BOOT: begin
        // One bubble cycle so the first fetch sees a settled PC.
        pc_freeze  = 1'b1;
        ifid_flush = 1'b1;
        state_d    = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (branch_vld) begin
          // The instruction in IF is on the wrong path, so any halt or
          // hazard it raises is dropped along with it.
          pc_sel     = 1'b1;
          pc_target  = branch_target;
          ifid_flush = 1'b1;
        end else if (!imem_ready) begin
          pc_freeze  = 1'b1;
          ifid_flush = 1'b1;
          tmo_d      = TMO_W'(1);
          state_d    = S_WAIT_MEM;
        end else if (halt_dec) begin
          pc_freeze  = 1'b1;
          ifid_flush = 1'b1;
          halted_d   = 1'b1;
          state_d    = S_HALTED;
        end else if (hazard_stall) begin
          // Hold both PC and IF/ID; the decode stage keeps its instruction.
          pc_freeze  = 1'b1;
        end else begin
          ifid_write = 1'b1;
        end
      end

      S_WAIT_MEM: begin
        imem_req   = 1'b1;
        pc_freeze  = 1'b1;
        ifid_flush = 1'b1;
        tmo_d      = tmo_q + TMO_W'(1);
        if (branch_vld) begin
          // Youngest redirect wins; it is replayed once memory answers.
          redir_d = 1'b1;
          tgt_d   = branch_target;
        end
        if (imem_ready) begin
          // The returned word is dropped: FETCH re-presents the same PC,
          // or REDIRECT moves the PC away first.
          tmo_d   = '0;
          state_d = (redir_q || branch_vld) ? S_REDIRECT : S_FETCH;
        end else if (tmo_q == TMO_LIMIT) begin
          tmo_d      = '0;
          imem_err_d = 1'b1;
          halted_d   = 1'b1;
          state_d    = S_HALTED;
        end
      end

      S_REDIRECT: begin
        // A branch resolving in this very cycle is younger than the latch.
        pc_sel     = 1'b1;
        pc_target  = branch_vld ? branch_target : tgt_q;
        ifid_flush = 1'b1;
        redir_d    = 1'b0;
        state_d    = S_FETCH;
      end

      S_HALTED: begin
        // Terminal until reset; every input is ignored.
        pc_freeze  = 1'b1;
        ifid_flush = 1'b1;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign halted   = halted_q;
  assign imem_err = imem_err_q;

`ifdef FETCH_PERF_CNT_EN
  // ------------------------------------------------------------------
  // Performance counters (saturating)
  // ------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        perf_active;

  assign perf_active = (state_q != S_BOOT) && (state_q != S_HALTED);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_active && pc_freeze && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (perf_active && ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
